// File: rtl/vga_scanout_gen_if.sv
// vga_scanout_gen_if: valid/ready pixel stream from the line fetch logic into the scanout generator.
interface vga_scanout_gen_if #(parameter int COLOR_BITS = 4);
  logic [3*COLOR_BITS-1:0] pix_data;
  logic pix_valid;
  logic pix_ready;
  modport master(output pix_data, pix_valid, input pix_ready);
  modport slave(input pix_data, pix_valid, output pix_ready);
endinterface

// File: rtl/vga_scanout_gen.sv
// vga_scanout_gen: VGA timing of any geometry, centred image window fed by a pixel stream, Z80-written border.
// Define VGA_FRAME_IRQ_EN to enable the frame interrupt on INT_N; otherwise INT_N is tied high.
module vga_scanout_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int HS_POL = 0,
  parameter int IMG_W = 512,
  parameter int IMG_H = 384,
  parameter int COLOR_BITS = 4,
  parameter int INT_CYCLES = 32
) (
  input  logic clk25,
  input  logic RESET,
  input  logic [7:0] A,
  input  logic [7:0] D,
  input  logic IORQ,
  input  logic WR,
  vga_scanout_gen_if.slave pix,
  output logic line_start,
  output logic frame_start,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] hcount,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] vcount,
  output logic HS,
  output logic VS,
  output logic [COLOR_BITS-1:0] RED,
  output logic [COLOR_BITS-1:0] GREEN,
  output logic [COLOR_BITS-1:0] BLUE,
  output logic underflow,
  input  logic underflow_clr,
  output logic INT_N
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] h_last = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] h_act = HW'(H_ACTIVE);
  localparam logic [HW-1:0] hs_beg = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] hs_end = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] ix_beg = HW'((H_ACTIVE - IMG_W) / 2);
  localparam logic [HW-1:0] ix_end = HW'((H_ACTIVE - IMG_W) / 2 + IMG_W);
  localparam logic [VW-1:0] v_last = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] v_act = VW'(V_ACTIVE);
  localparam logic [VW-1:0] vs_beg = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] vs_end = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] iy_beg = VW'((V_ACTIVE - IMG_H) / 2);
  localparam logic [VW-1:0] iy_end = VW'((V_ACTIVE - IMG_H) / 2 + IMG_H);
  localparam logic pol = HS_POL != 0;
  logic active, image, take, strobe, strobe_q, wr_hit, unused_bits;
  logic [5:0] s1, s2;
  logic [2:0] border;
  logic [3*COLOR_BITS-1:0] border_rgb;
  assign unused_bits = ^{A[7:1], D[7:3]};
  assign active = hcount < h_act && vcount < v_act;
  assign image = active && hcount >= ix_beg && hcount < ix_end && vcount >= iy_beg && vcount < iy_end;
  assign take = image && pix.pix_valid;
  assign pix.pix_ready = image;
  assign line_start = RESET && hcount == '0;
  assign frame_start = line_start && vcount == '0;
  // Sync stage order: {IORQ, WR, A[0], D[2:0]}; strobes idle high out of reset so no false edge.
  assign strobe = s2[5] | s2[4];
  assign wr_hit = strobe_q && !strobe && !s2[3];
  assign border_rgb = {{COLOR_BITS{border[1]}}, {COLOR_BITS{border[2]}}, {COLOR_BITS{border[0]}}};
  always_ff @(posedge clk25 or negedge RESET)
    if (!RESET) begin
      s1 <= 6'b111000;
      s2 <= 6'b111000;
      strobe_q <= 1'b1;
      border <= '0;
    end else begin
      s1 <= {IORQ, WR, A[0], D[2:0]};
      s2 <= s1;
      strobe_q <= strobe;
      if (wr_hit) border <= s2[2:0];
    end
  always_ff @(posedge clk25 or negedge RESET)
    if (!RESET) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= hcount == h_last ? '0 : hcount + HW'(1);
      if (hcount == h_last) vcount <= vcount == v_last ? '0 : vcount + VW'(1);
    end
  // One output stage keeps colour and sync aligned to the same counter sample.
  always_ff @(posedge clk25 or negedge RESET)
    if (!RESET) begin
      {RED, GREEN, BLUE} <= '0;
      HS <= !pol;
      VS <= !pol;
      underflow <= 1'b0;
    end else begin
      {RED, GREEN, BLUE} <= take ? pix.pix_data : active ? border_rgb : '0;
      HS <= hcount >= hs_beg && hcount < hs_end ? pol : !pol;
      VS <= vcount >= vs_beg && vcount < vs_end ? pol : !pol;
      underflow <= (image && !pix.pix_valid) || (underflow && !underflow_clr);
    end
`ifdef VGA_FRAME_IRQ_EN
  localparam int IW = $clog2(INT_CYCLES + 1);
  logic [IW-1:0] int_cnt;
  always_ff @(posedge clk25 or negedge RESET)
    if (!RESET) int_cnt <= '0;
    else int_cnt <= frame_start ? IW'(INT_CYCLES) : int_cnt != '0 ? int_cnt - IW'(1) : int_cnt;
  assign INT_N = int_cnt == '0;
`else
  localparam int unused_int_cycles = INT_CYCLES;
  assign INT_N = 1'b1;
`endif
endmodule

// File: tb/tb_vga_scanout_gen.sv
// tb_vga_scanout_gen: directed vectors on a reduced 25x17 geometry with an 8x6 image window at (4,3).
module tb_vga_scanout_gen;
  logic clk25 = 1'b0, RESET = 1'b1, IORQ = 1'b1, WR = 1'b1, underflow_clr = 1'b0;
  logic [7:0] A = 8'hFF, D = 8'h00;
  logic line_start, frame_start, HS, VS, underflow, INT_N;
  logic [4:0] hcount, vcount;
  logic [3:0] RED, GREEN, BLUE;
  int pass_cnt = 0, total = 0;
  vga_scanout_gen_if #(.COLOR_BITS(4)) pix();
  vga_scanout_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .IMG_W(8), .IMG_H(6)
  ) dut (
    .clk25(clk25), .RESET(RESET), .A(A), .D(D), .IORQ(IORQ), .WR(WR), .pix(pix),
    .line_start(line_start), .frame_start(frame_start), .hcount(hcount), .vcount(vcount),
    .HS(HS), .VS(VS), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .underflow(underflow), .underflow_clr(underflow_clr), .INT_N(INT_N)
  );
  always #5 clk25 = ~clk25;
  // kind: 0 blanking, 1 border, 2 image pixel
  typedef struct {int h; int v; logic rdy; logic ls; logic fs; int kind; logic hs; logic vs;} vec_t;
  vec_t vecs[17];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic goto(int h, int v);
    int n = 0;
    do begin
      @(negedge clk25);
      n++;
    end while (!(hcount == h && vcount == v) && n < 1000);
    if (n >= 1000) check($sformatf("goto(%0d,%0d) timeout", h, v), {hcount, vcount}, 32'(h * 32 + v));
  endtask
  task automatic run_table(logic [11:0] bcol);
    for (int i = 0; i < 17; i++) begin
      goto(vecs[i].h, vecs[i].v);
      check($sformatf("pix_ready[%0d]", i), pix.pix_ready, vecs[i].rdy);
      check($sformatf("line_start[%0d]", i), line_start, vecs[i].ls);
      check($sformatf("frame_start[%0d]", i), frame_start, vecs[i].fs);
      @(negedge clk25);
      check($sformatf("rgb[%0d]", i), {RED, GREEN, BLUE},
            vecs[i].kind == 2 ? 12'h5A3 : vecs[i].kind == 1 ? bcol : 12'h000);
      check($sformatf("hs[%0d]", i), HS, vecs[i].hs);
      check($sformatf("vs[%0d]", i), VS, vecs[i].vs);
    end
    check("underflow_idle", underflow, 1'b0);
  endtask
  initial begin
    int fs_n, vs_low, int_low, int_first, hs_low, hs_first;
    vecs = '{
      '{0, 0, 0, 1, 1, 1, 1, 1}, '{4, 3, 1, 0, 0, 2, 1, 1}, '{11, 8, 1, 0, 0, 2, 1, 1},
      '{12, 8, 0, 0, 0, 1, 1, 1}, '{3, 3, 0, 0, 0, 1, 1, 1}, '{4, 9, 0, 0, 0, 1, 1, 1},
      '{4, 2, 0, 0, 0, 1, 1, 1}, '{18, 5, 0, 0, 0, 0, 0, 1}, '{21, 5, 0, 0, 0, 0, 0, 1},
      '{22, 5, 0, 0, 0, 0, 1, 1}, '{17, 5, 0, 0, 0, 0, 1, 1}, '{0, 13, 0, 1, 0, 0, 1, 0},
      '{5, 14, 0, 0, 0, 0, 1, 0}, '{5, 15, 0, 0, 0, 0, 1, 1}, '{15, 11, 0, 0, 0, 1, 1, 1},
      '{16, 3, 0, 0, 0, 0, 1, 1}, '{0, 12, 0, 1, 0, 0, 1, 1}
    };
    pix.pix_valid = 1'b1;
    pix.pix_data = 12'h5A3;
    #2 RESET = 1'b0;
    repeat (3) @(negedge clk25);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_rgb", {RED, GREEN, BLUE}, 0);
    check("rst_hs_vs", {HS, VS}, 2'b11);
    check("rst_flags", {underflow, INT_N, line_start, frame_start, pix.pix_ready}, 5'b01000);
    RESET = 1'b1;
    run_table(12'h000);
    goto(0, 0);
    fs_n = 0; vs_low = 0; int_low = 0; int_first = 0;
    for (int k = 1; k <= 425; k++) begin
      @(negedge clk25);
      fs_n += int'(frame_start);
      vs_low += int'(!VS);
      if (!INT_N) begin
        int_low++;
        if (int_first == 0) int_first = k;
      end
    end
    check("frame_start_per_frame", fs_n, 1);
    check("vs_low_clocks", vs_low, 50);
`ifdef VGA_FRAME_IRQ_EN
    check("int_low_clocks", int_low, 32);
    check("int_first_low", int_first, 1);
`else
    check("int_low_clocks", int_low, 0);
    check("int_first_low", int_first, 0);
`endif
    goto(0, 1);
    hs_low = 0; hs_first = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk25);
      if (!HS) begin
        hs_low++;
        if (hs_first == 0) hs_first = k;
      end
    end
    check("hs_low_clocks", hs_low, 4);
    check("hs_first_low", hs_first, 19);
    goto(12, 4);
    IORQ = 1'b0; WR = 1'b0; A = 8'hFE; D = 8'h02;
    repeat (4) @(negedge clk25);
    check("border_within_4", {RED, GREEN, BLUE}, 12'hF00);
    D = 8'h07;
    repeat (6) @(negedge clk25);
    IORQ = 1'b1; WR = 1'b1; A = 8'hFF; D = 8'h00;
    goto(13, 4);
    @(negedge clk25);
    check("border_hold_once", {RED, GREEN, BLUE}, 12'hF00);
    IORQ = 1'b0; WR = 1'b0; A = 8'hFF; D = 8'h07;
    repeat (6) @(negedge clk25);
    IORQ = 1'b1; WR = 1'b1; D = 8'h00;
    goto(14, 4);
    @(negedge clk25);
    check("border_a0_ignored", {RED, GREEN, BLUE}, 12'hF00);
    run_table(12'hF00);
    goto(6, 5);
    pix.pix_valid = 1'b0;
    check("uf_ready", pix.pix_ready, 1'b1);
    @(negedge clk25);
    pix.pix_valid = 1'b1;
    check("uf_pixel_border", {RED, GREEN, BLUE}, 12'hF00);
    check("uf_set", underflow, 1'b1);
    goto(20, 5);
    check("uf_sticky", underflow, 1'b1);
    underflow_clr = 1'b1;
    @(negedge clk25);
    underflow_clr = 1'b0;
    check("uf_cleared", underflow, 1'b0);
    goto(6, 6);
    pix.pix_valid = 1'b0;
    underflow_clr = 1'b1;
    @(negedge clk25);
    pix.pix_valid = 1'b1;
    underflow_clr = 1'b0;
    check("uf_set_beats_clr", underflow, 1'b1);
    goto(10, 7);
    RESET = 1'b0;
    #1;
    check("mid_rst_counters", {hcount, vcount}, 10'd0);
    check("mid_rst_rgb", {RED, GREEN, BLUE}, 12'h000);
    check("mid_rst_hs_vs", {HS, VS}, 2'b11);
    check("mid_rst_flags", {underflow, INT_N, line_start, frame_start}, 4'b0100);
    @(negedge clk25);
    @(negedge clk25);
    RESET = 1'b1;
    #1;
    check("post_rst_frame_start", frame_start, 1'b1);
    @(negedge clk25);
    check("post_rst_hcount", hcount, 1);
    goto(13, 4);
    @(negedge clk25);
    check("post_rst_border", {RED, GREEN, BLUE}, 12'h000);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
